// File: rtl/video_stream_monitor.sv
// Pixel-bus timing monitor: measures active/total frame geometry, counts frames and flags
// line-length and frame-size violations. Define VIDEO_MON_CRC_EN to add a per-frame CRC-16 output.
module video_stream_monitor #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned DW     = 8,
    parameter int unsigned CNT_W  = 12,
    parameter bit          VS_POL = 1'b1,
    parameter bit          HS_POL = 1'b1,
    parameter int unsigned EXP_W  = 0,
    parameter int unsigned EXP_H  = 0
) (
    input  logic                    pclk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic                    clr_i,
    input  logic                    vs_i,
    input  logic                    hs_i,
    input  logic                    de_i,
    input  logic [LANES*3*DW-1:0]   data_i,
    output logic [15:0]             frame_cnt_o,
    output logic [CNT_W-1:0]        h_active_o,
    output logic [CNT_W-1:0]        v_active_o,
    output logic [CNT_W-1:0]        h_total_o,
    output logic [CNT_W-1:0]        v_total_o,
    output logic                    meas_valid_o,
    output logic                    err_line_o,
    output logic                    err_size_o
`ifdef VIDEO_MON_CRC_EN
    ,
    output logic [15:0]             crc_o
`endif
);

    localparam int unsigned DATA_W = LANES * 3 * DW;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] STEP_PIX = CNT_W'(LANES);
    localparam bit CHK_W = (EXP_W != 0);
    localparam bit CHK_H = (EXP_H != 0);

    typedef enum logic [1:0] {IDLE, ALIGN, MEAS} state_t;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    state_t            state;
    logic              vs_d, hs_d, de_d;
    logic [CNT_W-1:0]  h_cnt, h_last, v_tot, v_act, len, ref_len;
    logic              ref_valid, split;

    // Normalised syncs and one-stage edge detection
    logic vs_n, hs_n, fs, hs_edge, de_rise, de_fall;
    assign vs_n    = vs_i ~^ VS_POL;
    assign hs_n    = hs_i ~^ HS_POL;
    assign fs      = vs_n & ~vs_d;
    assign hs_edge = hs_n & ~hs_d;
    assign de_rise = de_i & ~de_d;
    assign de_fall = ~de_i & de_d;

    logic run, meas, latch, line_end, line_bad, size_bad;
    logic [CNT_W-1:0] h_act_new, h_tot_new;
    assign run       = en_i & (state != IDLE);
    assign meas      = en_i & (state == MEAS);
    assign latch     = meas & fs;
    // Bursts cut by a frame start are neither a reference nor compared
    assign line_end  = de_fall & ~split;
    assign line_bad  = line_end & ref_valid & (len != ref_len);
    assign h_act_new = ref_valid ? ref_len : (line_end ? len : '0);
    assign h_tot_new = hs_edge ? h_cnt : h_last;
    assign size_bad  = (CHK_W && (h_act_new != CNT_W'(EXP_W))) ||
                       (CHK_H && (v_act != CNT_W'(EXP_H)));

    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            vs_d <= 1'b0;
            hs_d <= 1'b0;
            de_d <= 1'b0;
        end else begin
            vs_d <= vs_n;
            hs_d <= hs_n;
            de_d <= de_i;
        end
    end

    // Control FSM and registered results
    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            frame_cnt_o  <= '0;
            h_active_o   <= '0;
            v_active_o   <= '0;
            h_total_o    <= '0;
            v_total_o    <= '0;
            meas_valid_o <= 1'b0;
            err_line_o   <= 1'b0;
            err_size_o   <= 1'b0;
        end else begin
            meas_valid_o <= latch;
            case (state)
                IDLE:    if (en_i) state <= ALIGN;
                ALIGN:   if (!en_i) state <= IDLE;
                         else if (fs) state <= MEAS;
                MEAS:    if (!en_i) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (latch) begin
                h_active_o  <= h_act_new;
                v_active_o  <= v_act;
                h_total_o   <= h_tot_new;
                v_total_o   <= v_tot;
                frame_cnt_o <= clr_i ? 16'd1 : frame_cnt_o + 16'd1;
            end else if (clr_i) begin
                frame_cnt_o <= '0;
            end

            if (meas && line_bad) err_line_o <= 1'b1;
            else if (clr_i)       err_line_o <= 1'b0;

            if (latch && size_bad) err_size_o <= 1'b1;
            else if (clr_i)        err_size_o <= 1'b0;
        end
    end

    // Per-frame measurement counters; events on the fs cycle belong to the new frame
    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            h_cnt     <= '0;
            h_last    <= '0;
            v_tot     <= '0;
            v_act     <= '0;
            len       <= '0;
            ref_len   <= '0;
            ref_valid <= 1'b0;
            split     <= 1'b0;
        end else if (run) begin
            h_cnt <= hs_edge ? ONE : sat_add(h_cnt, ONE);
            if (hs_edge) h_last <= h_cnt;
            if (de_i) len <= (de_d && !fs) ? sat_add(len, STEP_PIX) : STEP_PIX;

            if (fs) begin
                v_tot     <= hs_edge ? ONE : '0;
                v_act     <= de_i ? ONE : '0;
                ref_valid <= 1'b0;
                split     <= de_i & de_d;
            end else begin
                if (hs_edge) v_tot <= sat_add(v_tot, ONE);
                if (de_rise) begin
                    v_act <= sat_add(v_act, ONE);
                    split <= 1'b0;
                end
                if (line_end && !ref_valid) begin
                    ref_valid <= 1'b1;
                    ref_len   <= len;
                end
            end
        end
    end

`ifdef VIDEO_MON_CRC_EN
    // CRC-16/CCITT, whole bus word per de cycle, MSB first
    function automatic logic [15:0] crc_step(input logic [15:0] c_in,
                                             input logic [DATA_W-1:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    logic [15:0] crc;

    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            crc   <= 16'hFFFF;
            crc_o <= '0;
        end else begin
            if (run) begin
                if (fs)        crc <= de_i ? crc_step(16'hFFFF, data_i) : 16'hFFFF;
                else if (de_i) crc <= crc_step(crc, data_i);
            end
            if (latch) crc_o <= crc;
        end
    end
`else
    logic unused_data;
    assign unused_data = ^data_i;
`endif

endmodule

// File: tb/tb_video_stream_monitor.sv
// Directed bench for video_stream_monitor: three instances (plain, size-checked, inverted vsync)
// observe one shared 48x12-clock stream with a 32-clock, 8-line active window.
module tb_video_stream_monitor;

    localparam int unsigned DATA_W = 48;

    logic clk = 1'b0;
    logic rst, en, clr, vs, hs, de, vs_inv;
    logic [DATA_W-1:0] data;
    assign vs_inv = ~vs;

    always #5 clk = ~clk;

    logic [15:0] a_frame, b_frame, c_frame;
    logic [11:0] a_hact, a_vact, a_htot, a_vtot;
    logic [11:0] b_hact, b_vact, b_htot, b_vtot;
    logic [11:0] c_hact, c_vact, c_htot, c_vtot;
    logic        a_mv, a_eline, a_esize, b_mv, b_eline, b_esize, c_mv, c_eline, c_esize;
`ifdef VIDEO_MON_CRC_EN
    logic [15:0] a_crc, b_crc, c_crc;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int mv_cnt = 0;

    video_stream_monitor u_a (
        .pclk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .vs_i(vs), .hs_i(hs), .de_i(de),
        .data_i(data), .frame_cnt_o(a_frame), .h_active_o(a_hact), .v_active_o(a_vact),
        .h_total_o(a_htot), .v_total_o(a_vtot), .meas_valid_o(a_mv), .err_line_o(a_eline),
        .err_size_o(a_esize)
`ifdef VIDEO_MON_CRC_EN
        , .crc_o(a_crc)
`endif
    );

    video_stream_monitor #(.EXP_W(64), .EXP_H(10)) u_b (
        .pclk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .vs_i(vs), .hs_i(hs), .de_i(de),
        .data_i(data), .frame_cnt_o(b_frame), .h_active_o(b_hact), .v_active_o(b_vact),
        .h_total_o(b_htot), .v_total_o(b_vtot), .meas_valid_o(b_mv), .err_line_o(b_eline),
        .err_size_o(b_esize)
`ifdef VIDEO_MON_CRC_EN
        , .crc_o(b_crc)
`endif
    );

    video_stream_monitor #(.VS_POL(1'b0)) u_c (
        .pclk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .vs_i(vs_inv), .hs_i(hs), .de_i(de),
        .data_i(data), .frame_cnt_o(c_frame), .h_active_o(c_hact), .v_active_o(c_vact),
        .h_total_o(c_htot), .v_total_o(c_vtot), .meas_valid_o(c_mv), .err_line_o(c_eline),
        .err_size_o(c_esize)
`ifdef VIDEO_MON_CRC_EN
        , .crc_o(c_crc)
`endif
    );

    always @(negedge clk) if (a_mv) mv_cnt++;

    // Drive one clock of stream, return at the following negedge
    task automatic drive_cycle(input logic v, input logic h, input logic d);
        vs = v; hs = h; de = d;
        @(negedge clk);
    endtask

    // Line l, cycles c0..c1: vs on lines 0-1, hs on cycles 0-3, de on lines 2-9 from cycle 8
    task automatic drive_span(input int l, input int de_len, input int c0, input int c1);
        for (int c = c0; c <= c1; c++)
            drive_cycle(l < 2, c < 4, (l >= 2) && (l < 10) && (c >= 8) && (c < 8 + de_len));
    endtask

    task automatic drive_lines(input int l0, input int l1);
        for (int l = l0; l <= l1; l++) drive_span(l, 32, 0, 47);
    endtask

    function automatic logic [15:0] crc_zero(input int nbits);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < nbits; i++) c = {c[14:0], 1'b0} ^ (c[15] ? 16'h1021 : 16'h0000);
        return c;
    endfunction

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; clr = 1'b0; vs = 1'b0; hs = 1'b0; de = 1'b0; data = '0;
        @(negedge clk);
        n_cmp++; if (a_frame !== 16'd0) begin n_bad++; $display("FAIL reset_frame: got %0d want 0", a_frame); end
        n_cmp++; if (a_hact !== 12'd0) begin n_bad++; $display("FAIL reset_hact: got %0d want 0", a_hact); end
        n_cmp++; if (a_vtot !== 12'd0) begin n_bad++; $display("FAIL reset_vtot: got %0d want 0", a_vtot); end
        n_cmp++; if ({a_mv, a_eline, a_esize} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {a_mv, a_eline, a_esize}); end
`ifdef VIDEO_MON_CRC_EN
        n_cmp++; if (a_crc !== 16'h0000) begin n_bad++; $display("FAIL reset_crc: got %h want 0000", a_crc); end
`endif
        rst = 1'b0; en = 1'b1;
        repeat (3) drive_cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_basic;
        drive_lines(0, 11);
        drive_span(0, 32, 0, 0);
        n_cmp++; if (a_mv !== 1'b1) begin n_bad++; $display("FAIL basic_mv_pulse: got %b want 1", a_mv); end
        n_cmp++; if (a_frame !== 16'd1) begin n_bad++; $display("FAIL basic_frame1: got %0d want 1", a_frame); end
        n_cmp++; if (a_hact !== 12'd64) begin n_bad++; $display("FAIL basic_hact1: got %0d want 64", a_hact); end
        n_cmp++; if (b_esize !== 1'b1) begin n_bad++; $display("FAIL size_err_first: got %b want 1", b_esize); end
        n_cmp++; if (a_esize !== 1'b0) begin n_bad++; $display("FAIL size_disabled: got %b want 0", a_esize); end
        drive_span(0, 32, 1, 1);
        n_cmp++; if (a_mv !== 1'b0) begin n_bad++; $display("FAIL basic_mv_width: got %b want 0", a_mv); end
        drive_span(0, 32, 2, 47);
        drive_lines(1, 11);
        drive_lines(0, 11);
        n_cmp++; if (mv_cnt !== 2) begin n_bad++; $display("FAIL basic_pulses: got %0d want 2", mv_cnt); end
        n_cmp++; if (a_frame !== 16'd2) begin n_bad++; $display("FAIL basic_frame: got %0d want 2", a_frame); end
        n_cmp++; if (a_hact !== 12'd64) begin n_bad++; $display("FAIL basic_hact: got %0d want 64", a_hact); end
        n_cmp++; if (a_vact !== 12'd8) begin n_bad++; $display("FAIL basic_vact: got %0d want 8", a_vact); end
        n_cmp++; if (a_htot !== 12'd48) begin n_bad++; $display("FAIL basic_htot: got %0d want 48", a_htot); end
        n_cmp++; if (a_vtot !== 12'd12) begin n_bad++; $display("FAIL basic_vtot: got %0d want 12", a_vtot); end
        n_cmp++; if ({a_eline, a_esize} !== 2'b00) begin n_bad++; $display("FAIL basic_errs: got %b want 00", {a_eline, a_esize}); end
        n_cmp++; if ({b_frame, b_hact, b_vact} !== {16'd2, 12'd64, 12'd8}) begin n_bad++; $display("FAIL size_inst_meas: got %0d/%0d/%0d want 2/64/8", b_frame, b_hact, b_vact); end
        n_cmp++; if ({b_htot, b_vtot, b_mv, b_eline, b_esize} !== {12'd48, 12'd12, 3'b001}) begin n_bad++; $display("FAIL size_inst_tot: got %0d/%0d/%b%b%b want 48/12/001", b_htot, b_vtot, b_mv, b_eline, b_esize); end
    endtask

    task automatic test_polarity;
        n_cmp++; if (c_frame !== 16'd2) begin n_bad++; $display("FAIL pol_frame: got %0d want 2", c_frame); end
        n_cmp++; if ({c_hact, c_vact} !== {12'd64, 12'd8}) begin n_bad++; $display("FAIL pol_active: got %0d/%0d want 64/8", c_hact, c_vact); end
        n_cmp++; if ({c_htot, c_vtot} !== {12'd48, 12'd12}) begin n_bad++; $display("FAIL pol_total: got %0d/%0d want 48/12", c_htot, c_vtot); end
        n_cmp++; if ({c_mv, c_eline, c_esize} !== 3'b000) begin n_bad++; $display("FAIL pol_flags: got %b want 000", {c_mv, c_eline, c_esize}); end
    endtask

    task automatic test_line_error;
        drive_lines(0, 11);
        drive_lines(0, 6);
        drive_span(7, 31, 0, 38);
        n_cmp++; if (a_eline !== 1'b0) begin n_bad++; $display("FAIL line_err_early: got %b want 0", a_eline); end
        drive_span(7, 31, 39, 39);
        n_cmp++; if (a_eline !== 1'b1) begin n_bad++; $display("FAIL line_err_set: got %b want 1", a_eline); end
        drive_span(7, 31, 40, 47);
        drive_lines(8, 11);
        drive_lines(0, 11);
        n_cmp++; if (a_eline !== 1'b1) begin n_bad++; $display("FAIL line_err_sticky: got %b want 1", a_eline); end
        n_cmp++; if (a_frame !== 16'd5) begin n_bad++; $display("FAIL line_err_frames: got %0d want 5", a_frame); end
    endtask

    task automatic test_clear;
        drive_span(0, 32, 0, 0);
        n_cmp++; if (a_frame !== 16'd6) begin n_bad++; $display("FAIL clr_pre_frame: got %0d want 6", a_frame); end
        clr = 1'b1;
        drive_span(0, 32, 1, 1);
        clr = 1'b0;
        n_cmp++; if (a_eline !== 1'b0) begin n_bad++; $display("FAIL clr_line: got %b want 0", a_eline); end
        n_cmp++; if (a_frame !== 16'd0) begin n_bad++; $display("FAIL clr_frame: got %0d want 0", a_frame); end
        n_cmp++; if (b_esize !== 1'b0) begin n_bad++; $display("FAIL clr_size: got %b want 0", b_esize); end
        n_cmp++; if (a_hact !== 12'd64) begin n_bad++; $display("FAIL clr_keeps_meas: got %0d want 64", a_hact); end
        drive_span(0, 32, 2, 47);
        drive_lines(1, 11);
        clr = 1'b1;
        drive_span(0, 32, 0, 0);
        clr = 1'b0;
        n_cmp++; if (a_frame !== 16'd1) begin n_bad++; $display("FAIL clr_collide_frame: got %0d want 1", a_frame); end
        n_cmp++; if (b_esize !== 1'b1) begin n_bad++; $display("FAIL clr_collide_size: got %b want 1", b_esize); end
        n_cmp++; if (a_mv !== 1'b1) begin n_bad++; $display("FAIL clr_collide_mv: got %b want 1", a_mv); end
    endtask

    task automatic test_enable;
        int m0;
        drive_span(0, 32, 1, 47);
        drive_lines(1, 4);
        m0 = mv_cnt;
        en = 1'b0;
        drive_lines(5, 6);
        drive_span(7, 32, 0, 3);
        en = 1'b1;
        drive_span(7, 32, 4, 47);
        drive_lines(8, 11);
        n_cmp++; if (a_frame !== 16'd1) begin n_bad++; $display("FAIL en_hold_frame: got %0d want 1", a_frame); end
        n_cmp++; if ({a_hact, a_vtot} !== {12'd64, 12'd12}) begin n_bad++; $display("FAIL en_hold_meas: got %0d/%0d want 64/12", a_hact, a_vtot); end
        drive_span(0, 32, 0, 0);
        n_cmp++; if (a_mv !== 1'b0) begin n_bad++; $display("FAIL en_align_no_pulse: got %b want 0", a_mv); end
        drive_span(0, 32, 1, 47);
        drive_lines(1, 11);
        n_cmp++; if (mv_cnt !== m0) begin n_bad++; $display("FAIL en_pulses: got %0d want %0d", mv_cnt, m0); end
        drive_span(0, 32, 0, 0);
        n_cmp++; if (a_mv !== 1'b1) begin n_bad++; $display("FAIL en_resume_mv: got %b want 1", a_mv); end
        n_cmp++; if (a_frame !== 16'd2) begin n_bad++; $display("FAIL en_resume_frame: got %0d want 2", a_frame); end
        n_cmp++; if ({a_vact, a_htot} !== {12'd8, 12'd48}) begin n_bad++; $display("FAIL en_resume_meas: got %0d/%0d want 8/48", a_vact, a_htot); end
    endtask

    task automatic test_async_reset;
        drive_span(0, 32, 1, 47);
        drive_lines(1, 4);
        drive_span(5, 32, 0, 19);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({a_frame, a_hact, a_vact} !== 40'd0) begin n_bad++; $display("FAIL arst_meas: got %0d/%0d/%0d want 0", a_frame, a_hact, a_vact); end
        n_cmp++; if ({a_htot, a_vtot} !== 24'd0) begin n_bad++; $display("FAIL arst_tot: got %0d/%0d want 0", a_htot, a_vtot); end
        n_cmp++; if ({a_mv, a_eline, a_esize, b_esize} !== 4'b0000) begin n_bad++; $display("FAIL arst_flags: got %b want 0000", {a_mv, a_eline, a_esize, b_esize}); end
        @(negedge clk);
        rst = 1'b0;
        drive_span(5, 32, 20, 47);
        drive_lines(6, 11);
        drive_span(0, 32, 0, 0);
        n_cmp++; if ({a_mv, a_frame} !== 17'd0) begin n_bad++; $display("FAIL arst_idle_restart: got %b/%0d want 0/0", a_mv, a_frame); end
        drive_span(0, 32, 1, 47);
        drive_lines(1, 11);
        drive_span(0, 32, 0, 0);
        n_cmp++; if ({a_mv, a_frame} !== {1'b1, 16'd1}) begin n_bad++; $display("FAIL arst_first_meas: got %b/%0d want 1/1", a_mv, a_frame); end
        n_cmp++; if ({a_hact, a_vact, a_htot, a_vtot} !== {12'd64, 12'd8, 12'd48, 12'd12}) begin n_bad++; $display("FAIL arst_values: got %0d/%0d/%0d/%0d want 64/8/48/12", a_hact, a_vact, a_htot, a_vtot); end
`ifdef VIDEO_MON_CRC_EN
        n_cmp++; if (a_crc !== crc_zero(256 * DATA_W)) begin n_bad++; $display("FAIL crc_a: got %h want %h", a_crc, crc_zero(256 * DATA_W)); end
        n_cmp++; if ({b_crc, c_crc} !== {2{crc_zero(256 * DATA_W)}}) begin n_bad++; $display("FAIL crc_bc: got %h/%h want %h", b_crc, c_crc, crc_zero(256 * DATA_W)); end
`endif
        drive_span(0, 32, 1, 47);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_polarity();
        test_line_error();
        test_clear();
        test_enable();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
